ram_io_responder: RTL and testbench

RAM_IO_RESPONDER -- requirements
Module: ram_io_responder

---
 rtl/ram_io_responder_pkg.sv | 27 ++
 rtl/byte_fifo.sv | 82 ++++++++
 rtl/ram_io_responder.sv | 132 +++++++++++++
 tb/tb_ram_io_responder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_io_responder_pkg.sv
// Shared constants for the RAM/IO responder slice.
// Holds the IO decode bits, the IO register addresses and the
// read-data source encoding used by the top level.
package ram_io_responder_pkg;

  // IO space is selected by address bits [17:16] == 2'b11
  localparam int          IO_DECODE_HI  = 17;
  localparam int          IO_DECODE_LO  = 16;
  localparam logic [1:0]  IO_DECODE_VAL = 2'b11;

  // IO register map
  localparam logic [31:0] IO_BASE_ADDR  = 32'h0003_0000;
  localparam logic [31:0] IO_HALT_ADDR  = 32'h0003_0004;

  // Source of mem_din in the cycle after an access
  typedef enum logic [1:0] {
    DIN_HOLD = 2'd0,
    DIN_RAM  = 2'd1,
    DIN_IO   = 2'd2
  } din_src_e;

  // True when the decode bits select IO space
  function automatic logic is_io_decode(input logic [1:0] decode_bits);
    return (decode_bits == IO_DECODE_VAL);
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide transmit FIFO with wrap-around pointers.
// Ports:
//   clk_in, rst_n_in : clock, async active-low reset
//   push, push_data  : enqueue request and byte
//   pop_req          : sink ready; pops the head when not empty
//   head_data        : head entry, combinational
//   not_empty        : count != 0
//   almost_full      : registered (count >= DEPTH-1)
//   overflow         : sticky, set when a push is dropped on a full queue
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop_req,
  output logic [7:0] head_data,
  output logic       not_empty,
  output logic       almost_full,
  output logic       overflow
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [7:0]       buf_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next_s;
  logic             almost_full_r;
  logic             overflow_r;
  logic             full_s;
  logic             pop_s;
  logic             push_ok_s;

  assign full_s    = (count_r == CNT_W'(DEPTH));
  assign pop_s     = (count_r != {CNT_W{1'b0}}) && pop_req;
  // A full queue still accepts a push when the head leaves in the same cycle
  assign push_ok_s = push && (!full_s || pop_s);

  // Next occupancy from the accepted push and pop
  always_comb begin
    count_next_s = count_r;
    if (push_ok_s && !pop_s) begin
      count_next_s = count_r + CNT_W'(1);
    end else if (pop_s && !push_ok_s) begin
      count_next_s = count_r - CNT_W'(1);
    end else begin
      count_next_s = count_r;
    end
  end

  // Pointers, occupancy, near-full and overflow flags
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rd_ptr_r      <= {PTR_W{1'b0}};
      wr_ptr_r      <= {PTR_W{1'b0}};
      count_r       <= {CNT_W{1'b0}};
      almost_full_r <= 1'b0;
      overflow_r    <= 1'b0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)     rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      count_r       <= count_next_s;
      // Registered from the next count so it tracks the current count
      almost_full_r <= (count_next_s >= CNT_W'(DEPTH - 1));
      if (push && full_s && !pop_s) overflow_r <= 1'b1;
    end
  end

  // Storage array; contents need no reset since count gates visibility
  always_ff @(posedge clk_in) begin
    if (push_ok_s) buf_r[wr_ptr_r] <= push_data;
  end

  assign head_data   = buf_r[rd_ptr_r];
  assign not_empty   = (count_r != {CNT_W{1'b0}});
  assign almost_full = almost_full_r;
  assign overflow    = overflow_r;

endmodule

// File: rtl/ram_io_responder.sv
// Single-cycle byte responder: block RAM plus a small IO map
// (UART transmit queue at IO_BASE_ADDR, halt flag at IO_HALT_ADDR).
// Ports:
//   clk_in, rst_n_in        : clock, async active-low reset
//   mem_wr, mem_a, mem_dout : initiator access (one per cycle)
//   mem_din                 : read data, one cycle after the request
//   io_buffer_full          : initiator must stop writing the UART queue
//   uart_rx_data            : byte returned on reads of IO_BASE_ADDR
//   tx_data/tx_valid/tx_ready : transmit queue output handshake
//   sim_halt, tx_overflow   : sticky status flags
module ram_io_responder
  import ram_io_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 17,
  parameter int TXQ_DEPTH  = 8
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        mem_wr,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  input  logic [7:0]  uart_rx_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        sim_halt,
  output logic        tx_overflow
);
  localparam int RAM_BYTES = 2 ** ADDR_WIDTH;

  logic [7:0]            ram_r [RAM_BYTES];
  logic [7:0]            ram_q_r;
  logic [ADDR_WIDTH-1:0] ram_idx_s;
  logic                  is_io_s;
  logic                  ram_we_s;
  logic                  tx_push_s;
  logic                  halt_set_s;
  logic [7:0]            io_rd_s;
  logic [7:0]            io_q_r;
  logic [7:0]            last_din_r;
  logic [7:0]            mem_din_s;
  logic                  sim_halt_r;
  din_src_e              din_src_r;
  din_src_e              din_src_next_s;

  assign ram_idx_s  = mem_a[ADDR_WIDTH-1:0];
  assign is_io_s    = is_io_decode(mem_a[IO_DECODE_HI:IO_DECODE_LO]);
  assign ram_we_s   = mem_wr && !is_io_s;
  assign tx_push_s  = mem_wr && (mem_a == IO_BASE_ADDR);
  assign halt_set_s = mem_wr && (mem_a == IO_HALT_ADDR);

  // IO read value, captured in the request cycle
  always_comb begin
    io_rd_s = 8'h00;
    if (mem_a == IO_BASE_ADDR) begin
      io_rd_s = uart_rx_data;
    end else if (mem_a == IO_HALT_ADDR) begin
      io_rd_s = {7'b000_0000, io_buffer_full};
    end else begin
      io_rd_s = 8'h00;
    end
  end

  // Pick which registered value drives mem_din next cycle; writes hold it
  always_comb begin
    din_src_next_s = DIN_HOLD;
    if (mem_wr) begin
      din_src_next_s = DIN_HOLD;
    end else if (is_io_s) begin
      din_src_next_s = DIN_IO;
    end else begin
      din_src_next_s = DIN_RAM;
    end
  end

  // Single-port RAM, no-change on write; read data lands a cycle later.
  // A write commits at the edge, so a read in the next cycle sees it.
  always_ff @(posedge clk_in) begin
    if (ram_we_s) begin
      ram_r[ram_idx_s] <= mem_dout;
    end else begin
      ram_q_r <= ram_r[ram_idx_s];
    end
  end

  // Read-path select, IO capture, last visible value and halt flag
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      din_src_r  <= DIN_HOLD;
      io_q_r     <= 8'h00;
      last_din_r <= 8'h00;
      sim_halt_r <= 1'b0;
    end else begin
      din_src_r  <= din_src_next_s;
      io_q_r     <= io_rd_s;
      last_din_r <= mem_din_s;
      if (halt_set_s) sim_halt_r <= 1'b1;
    end
  end

  // mem_din is a mux of registers only, so it is glitch-free after the edge.
  // The RAM output register has no reset; DIN_HOLD with last_din_r=0 covers reset.
  always_comb begin
    mem_din_s = last_din_r;
    case (din_src_r)
      DIN_RAM:  mem_din_s = ram_q_r;
      DIN_IO:   mem_din_s = io_q_r;
      DIN_HOLD: mem_din_s = last_din_r;
      default:  mem_din_s = last_din_r;
    endcase
  end

  byte_fifo #(
    .DEPTH (TXQ_DEPTH)
  ) u_txq (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .push        (tx_push_s),
    .push_data   (mem_dout),
    .pop_req     (tx_ready),
    .head_data   (tx_data),
    .not_empty   (tx_valid),
    .almost_full (io_buffer_full),
    .overflow    (tx_overflow)
  );

  assign mem_din  = mem_din_s;
  assign sim_halt = sim_halt_r;

endmodule

// File: tb/tb_ram_io_responder.sv
// Self-checking bench for ram_io_responder: directed scenarios plus a
// randomized run, all checked against a queue/array reference model.
module tb_ram_io_responder;
  localparam int DEPTH = 8;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        mem_wr;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  uart_rx_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        sim_halt;
  logic        tx_overflow;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0] ram_m [int];
  logic [7:0] q_m [$];
  logic [7:0] din_m;
  logic       halt_m;
  logic       ovf_m;

  ram_io_responder #(.ADDR_WIDTH(17), .TXQ_DEPTH(DEPTH)) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .mem_wr         (mem_wr),
    .mem_a          (mem_a),
    .mem_dout       (mem_dout),
    .mem_din        (mem_din),
    .io_buffer_full (io_buffer_full),
    .uart_rx_data   (uart_rx_data),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .sim_halt       (sim_halt),
    .tx_overflow    (tx_overflow)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  function automatic int ram_key(input logic [31:0] a);
    return int'(a & 32'h0001_FFFF);
  endfunction

  task automatic model_reset();
    q_m.delete();
    din_m  = 8'h00;
    halt_m = 1'b0;
    ovf_m  = 1'b0;
  endtask

  task automatic drive(input logic wr, input logic [31:0] a, input logic [7:0] d);
    mem_wr   = wr;
    mem_a    = a;
    mem_dout = d;
  endtask

  // Apply the current access to the model, then advance one clock
  task automatic step();
    logic is_io, pop, push;
    int   k;
    is_io = (mem_a[17:16] == 2'b11);
    pop   = (q_m.size() != 0) && tx_ready;
    push  = mem_wr && (mem_a == 32'h0003_0000);
    k     = ram_key(mem_a);
    if (mem_wr) begin
      if (!is_io) ram_m[k] = mem_dout;
      if (mem_a == 32'h0003_0004) halt_m = 1'b1;
    end else if (!is_io) begin
      din_m = ram_m.exists(k) ? ram_m[k] : 8'h00;
    end else if (mem_a == 32'h0003_0000) begin
      din_m = uart_rx_data;
    end else if (mem_a == 32'h0003_0004) begin
      din_m = {7'b000_0000, (q_m.size() >= DEPTH - 1)};
    end else begin
      din_m = 8'h00;
    end
    if (push && q_m.size() == DEPTH && !pop) begin
      ovf_m = 1'b1;
      push  = 1'b0;
    end
    if (pop)  void'(q_m.pop_front());
    if (push) q_m.push_back(mem_dout);
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    tx_ready = 1'b0;
    uart_rx_data = 8'h00;
    drive(1'b0, 32'h0003_0008, 8'h00);
    repeat (2) @(posedge clk_in);
    #1;
    model_reset();
    total++; if (mem_din !== 8'h00) begin bad++; $display("FAIL reset_din: got %h want 00", mem_din); end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", tx_valid); end
    total++; if (io_buffer_full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", io_buffer_full); end
    total++; if (sim_halt !== 1'b0) begin bad++; $display("FAIL reset_halt: got %b want 0", sim_halt); end
    total++; if (tx_overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", tx_overflow); end
    rst_n_in = 1'b1;
  endtask

  task automatic test_ram_wr_rd();
    drive(1'b1, 32'h0000_0010, 8'hA5); step();
    total++; if (mem_din !== din_m) begin bad++; $display("FAIL hold_after_wr: got %h want %h", mem_din, din_m); end
    drive(1'b0, 32'h0000_0010, 8'h00); step();
    total++; if (mem_din !== 8'hA5) begin bad++; $display("FAIL wr_then_rd: got %h want a5", mem_din); end
    drive(1'b1, 32'h0000_0020, 8'h3C); step();
    total++; if (mem_din !== 8'hA5) begin bad++; $display("FAIL hold_a5: got %h want a5", mem_din); end
    drive(1'b0, 32'h0000_0020, 8'h00); step();
    total++; if (mem_din !== 8'h3C) begin bad++; $display("FAIL rd_3c: got %h want 3c", mem_din); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h0000_0100 + 32'(i), vals[i]); step();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0000_0100 + 32'(i), 8'h00); step();
      total++;
      if (mem_din !== vals[i]) begin bad++; $display("FAIL b2b_rd%0d: got %h want %h", i, mem_din, vals[i]); end
    end
  endtask

  task automatic test_io_read();
    uart_rx_data = 8'h5A;
    drive(1'b0, 32'h0003_0000, 8'h00); step();
    uart_rx_data = 8'h00;
    total++; if (mem_din !== 8'h5A) begin bad++; $display("FAIL uart_rd: got %h want 5a", mem_din); end
    drive(1'b0, 32'h0003_0008, 8'h00); step();
    total++; if (mem_din !== 8'h00) begin bad++; $display("FAIL io_other_rd: got %h want 00", mem_din); end
    drive(1'b0, 32'h0003_0004, 8'h00); step();
    total++; if (mem_din !== 8'h00) begin bad++; $display("FAIL status_rd: got %h want 00", mem_din); end
    drive(1'b1, 32'h0003_000C, 8'hFF); step();
    total++; if (tx_valid !== 1'b0 || sim_halt !== 1'b0) begin
      bad++; $display("FAIL io_other_wr: got valid=%b halt=%b want 0 0", tx_valid, sim_halt); end
  endtask

  task automatic test_tx_fill();
    tx_ready = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      drive(1'b1, 32'h0003_0000, 8'(8'h40 + i)); step();
      total++;
      if (io_buffer_full !== (i >= 7)) begin bad++; $display("FAIL fill_full%0d: got %b want %b", i, io_buffer_full, (i >= 7)); end
      total++;
      if (tx_valid !== 1'b1 || tx_data !== q_m[0]) begin
        bad++; $display("FAIL fill_head%0d: got %b/%h want 1/%h", i, tx_valid, tx_data, q_m[0]); end
    end
    drive(1'b0, 32'h0003_0004, 8'h00); step();
    total++; if (mem_din !== 8'h01) begin bad++; $display("FAIL status_full: got %h want 01", mem_din); end
    drive(1'b1, 32'h0003_0000, 8'h48); step();
    total++; if (tx_overflow !== 1'b0) begin bad++; $display("FAIL eighth_ovf: got %b want 0", tx_overflow); end
    drive(1'b1, 32'h0003_0000, 8'h49); step();
    total++; if (tx_overflow !== 1'b1) begin bad++; $display("FAIL ninth_ovf: got %b want 1", tx_overflow); end
  endtask

  task automatic test_full_push_pop();
    int n;
    tx_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      total++;
      if (tx_data !== q_m[0]) begin bad++; $display("FAIL pp_head%0d: got %h want %h", i, tx_data, q_m[0]); end
      drive(1'b1, 32'h0003_0000, 8'(8'h80 + i)); step();
      total++;
      if (io_buffer_full !== 1'b1 || tx_valid !== 1'b1) begin
        bad++; $display("FAIL pp_full%0d: got %b/%b want 1/1", i, io_buffer_full, tx_valid); end
    end
    drive(1'b0, 32'h0003_0008, 8'h00);
    n = 0;
    while (tx_valid === 1'b1 && n < 20) begin
      total++;
      if (tx_data !== q_m[0]) begin bad++; $display("FAIL drain%0d: got %h want %h", n, tx_data, q_m[0]); end
      step();
      n++;
    end
    total++; if (n != DEPTH) begin bad++; $display("FAIL drain_count: got %0d want %0d", n, DEPTH); end
    total++; if (tx_overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", tx_overflow); end
  endtask

  task automatic test_halt();
    drive(1'b1, 32'h0003_0004, 8'h00); step();
    total++; if (sim_halt !== 1'b1) begin bad++; $display("FAIL halt_set: got %b want 1", sim_halt); end
    drive(1'b0, 32'h0003_0008, 8'h00);
    repeat (10) step();
    total++; if (sim_halt !== 1'b1) begin bad++; $display("FAIL halt_sticky: got %b want 1", sim_halt); end
    // Reset in the middle of a RAM read
    drive(1'b0, 32'h0000_0010, 8'h00);
    #2;
    rst_n_in = 1'b0;
    #1;
    total++; if (sim_halt !== 1'b0) begin bad++; $display("FAIL halt_async_clr: got %b want 0", sim_halt); end
    model_reset();
    @(posedge clk_in);
    #1;
    total++; if (mem_din !== 8'h00 || tx_overflow !== 1'b0 || tx_valid !== 1'b0) begin
      bad++; $display("FAIL rst_midaccess: got din=%h ovf=%b valid=%b want 00 0 0", mem_din, tx_overflow, tx_valid); end
    rst_n_in = 1'b1;
    drive(1'b0, 32'h0000_0010, 8'h00); step();
    total++; if (mem_din !== 8'hA5) begin bad++; $display("FAIL ram_retained: got %h want a5", mem_din); end
  endtask

  task automatic test_random();
    logic [31:0] pool [16];
    int          r;
    for (int i = 0; i < 16; i++) begin
      pool[i] = 32'($urandom_range(0, 32'h0002_FFFF));
      drive(1'b1, pool[i], 8'($urandom)); step();
    end
    for (int c = 0; c < 400; c++) begin
      r = $urandom_range(0, 99);
      tx_ready     = 1'($urandom);
      uart_rx_data = 8'($urandom);
      if (r < 35)      drive(1'b1, pool[$urandom_range(0, 15)], 8'($urandom));
      else if (r < 65) drive(1'b0, pool[$urandom_range(0, 15)], 8'h00);
      else if (r < 85) drive(1'b1, 32'h0003_0000, 8'($urandom));
      else if (r < 90) drive(1'b0, 32'h0003_0000, 8'h00);
      else if (r < 95) drive(1'b0, 32'h0003_0004, 8'h00);
      else if (r < 98) drive(1'($urandom), 32'h0003_000C, 8'($urandom));
      else             drive(1'b1, 32'h0003_0004, 8'h00);
      step();
      total++; if (mem_din !== din_m) begin bad++; $display("FAIL rnd_din c%0d: got %h want %h", c, mem_din, din_m); end
      total++; if (tx_valid !== (q_m.size() != 0)) begin bad++; $display("FAIL rnd_valid c%0d: got %b want %b", c, tx_valid, (q_m.size() != 0)); end
      if (q_m.size() != 0) begin
        total++; if (tx_data !== q_m[0]) begin bad++; $display("FAIL rnd_head c%0d: got %h want %h", c, tx_data, q_m[0]); end
      end
      total++; if (io_buffer_full !== (q_m.size() >= DEPTH - 1)) begin
        bad++; $display("FAIL rnd_full c%0d: got %b want %b", c, io_buffer_full, (q_m.size() >= DEPTH - 1)); end
      total++; if (tx_overflow !== ovf_m) begin bad++; $display("FAIL rnd_ovf c%0d: got %b want %b", c, tx_overflow, ovf_m); end
      total++; if (sim_halt !== halt_m) begin bad++; $display("FAIL rnd_halt c%0d: got %b want %b", c, sim_halt, halt_m); end
    end
  endtask

  initial begin
    test_reset();
    test_ram_wr_rd();
    test_back_to_back();
    test_io_read();
    test_tx_fill();
    test_full_push_pop();
    test_halt();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
